// File: rtl/crop_window.sv
// crop_window
// Crops a rectangular window out of an incoming pixel stream with exactly one
// clock of latency. The window configuration is sampled into shadow
// registers at the start of each frame, so it can be rewritten at any time
// without tearing the frame currently in flight. With EN low the block is a
// plain one-cycle register stage while the counters and FSM keep tracking,
// so cropping can resume cleanly.
//
// Ports:
//   clk        pixel clock, rising edge
//   rst_n      asynchronous active-low reset
//   EN         1 = crop, 0 = registered pass-through
//   x_start    first kept column (0-based)
//   y_start    first kept line (0-based)
//   crop_w     kept pixels per line
//   crop_h     kept lines per frame
//   pre_vs     input frame sync, active high
//   pre_de     input pixel valid
//   pre_data   input RGB888 pixel
//   post_vs    pre_vs delayed one cycle
//   post_de    output pixel valid
//   post_data  output RGB888 pixel (zero outside the window when cropping)
module crop_window #(
    parameter logic [11:0] H_DISP = 12'd1280,
    parameter logic [11:0] V_DISP = 12'd720
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic [11:0] x_start,
    input  logic [11:0] y_start,
    input  logic [11:0] crop_w,
    input  logic [11:0] crop_h,
    input  logic        pre_vs,
    input  logic        pre_de,
    input  logic [23:0] pre_data,
    output logic        post_vs,
    output logic        post_de,
    output logic [23:0] post_data
);

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_LINE,
        IN_LINE,
        FRAME_DONE
    } state_t;

    state_t      state;
    state_t      state_n;

    logic        vs_d;
    logic        de_d;
    logic [11:0] sh_x;
    logic [11:0] sh_y;
    logic [11:0] sh_w;
    logic [11:0] sh_h;
    logic [11:0] px;
    logic [11:0] ly;

    logic        vs_rise;
    logic        vs_fall;
    logic        de_fall;
    logic [12:0] x_sum;
    logic [12:0] y_sum;
    logic [12:0] x_end;
    logic [12:0] y_end;
    logic        in_win;
    logic        post_de_n;
    logic [23:0] post_data_n;

    assign vs_rise = pre_vs & ~vs_d;
    assign vs_fall = ~pre_vs & vs_d;
    assign de_fall = ~pre_de & de_d;

    // Window end bounds are computed one bit wider than the coordinates so
    // start+size can never wrap, then clipped to the active frame size.
    assign x_sum  = {1'b0, sh_x} + {1'b0, sh_w};
    assign y_sum  = {1'b0, sh_y} + {1'b0, sh_h};
    assign x_end  = (x_sum > {1'b0, H_DISP}) ? {1'b0, H_DISP} : x_sum;
    assign y_end  = (y_sum > {1'b0, V_DISP}) ? {1'b0, V_DISP} : y_sum;

    assign in_win = ({1'b0, px} >= {1'b0, sh_x}) && ({1'b0, px} < x_end) &&
                    ({1'b0, ly} >= {1'b0, sh_y}) && ({1'b0, ly} < y_end);

    // Edge-detect history and the frame-start shadow copy of the window.
    // The shadow registers come out of reset as a full-frame window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b0;
            de_d <= 1'b0;
            sh_x <= 12'd0;
            sh_y <= 12'd0;
            sh_w <= H_DISP;
            sh_h <= V_DISP;
        end else begin
            vs_d <= pre_vs;
            de_d <= pre_de;
            if (vs_rise) begin
                sh_x <= x_start;
                sh_y <= y_start;
                sh_w <= crop_w;
                sh_h <= crop_h;
            end
        end
    end

    // px holds the column of the pixel currently on pre_data while pre_de is
    // high; ly holds the index of the current line. Both saturate at 4095.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px <= 12'd0;
            ly <= 12'd0;
        end else begin
            if (pre_vs || !pre_de) begin
                px <= 12'd0;
            end else if (px != 12'hFFF) begin
                px <= px + 12'd1;
            end

            if (pre_vs) begin
                ly <= 12'd0;
            end else if (de_fall && (ly != 12'hFFF)) begin
                ly <= ly + 12'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_VS;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output logic. After reset nothing is emitted until
    // a whole sync pulse has passed, so a frame interrupted by reset stays
    // blank. A sync pulse in any later state restarts line tracking.
    always_comb begin
        state_n     = state;
        post_de_n   = 1'b0;
        post_data_n = 24'h000000;

        case (state)
            WAIT_VS: begin
                if (vs_fall) begin
                    state_n = WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                if (pre_de) begin
                    state_n = IN_LINE;
                end
            end
            IN_LINE: begin
                if (de_fall) begin
                    if (({1'b0, ly} + 13'd1) >= y_end) begin
                        state_n = FRAME_DONE;
                    end else begin
                        state_n = WAIT_LINE;
                    end
                end
            end
            FRAME_DONE: begin
                if (pre_vs) begin
                    state_n = WAIT_LINE;
                end
            end
            default: begin
                state_n = WAIT_VS;
            end
        endcase

        if (pre_vs && (state != WAIT_VS)) begin
            state_n = WAIT_LINE;
        end

        if (EN) begin
            post_de_n   = pre_de && in_win &&
                          ((state == WAIT_LINE) || (state == IN_LINE));
            post_data_n = in_win ? pre_data : 24'h000000;
        end else begin
            post_de_n   = pre_de;
            post_data_n = pre_data;
        end
    end

    // Output register: the single cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_vs   <= 1'b0;
            post_de   <= 1'b0;
            post_data <= 24'h000000;
        end else begin
            post_vs   <= pre_vs;
            post_de   <= post_de_n;
            post_data <= post_data_n;
        end
    end

endmodule

// File: tb/tb_crop_window.sv
// tb_crop_window
// Directed bench for crop_window using a reduced 40x24 frame so that every
// scenario fits in a few thousand cycles. Each pixel carries its own
// coordinates as data ({line, column}), which makes first/last kept pixels
// easy to state by hand. A negedge monitor gathers per-frame statistics
// (output line count, line lengths, pixel total, first/last pixel) and
// counts one-cycle latency / pass-through / sync-delay violations.
module tb_crop_window;

    localparam int HACT = 40;
    localparam int VACT = 24;

    logic        clk;
    logic        rst_n;
    logic        EN;
    logic [11:0] x_start;
    logic [11:0] y_start;
    logic [11:0] crop_w;
    logic [11:0] crop_h;
    logic        pre_vs;
    logic        pre_de;
    logic [23:0] pre_data;
    logic        post_vs;
    logic        post_de;
    logic [23:0] post_data;

    crop_window #(
        .H_DISP(12'd40),
        .V_DISP(12'd24)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .EN       (EN),
        .x_start  (x_start),
        .y_start  (y_start),
        .crop_w   (crop_w),
        .crop_h   (crop_h),
        .pre_vs   (pre_vs),
        .pre_de   (pre_de),
        .pre_data (pre_data),
        .post_vs  (post_vs),
        .post_de  (post_de),
        .post_data(post_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;

    // Reference copies of the inputs as the DUT saw them at the last edge.
    logic        prevVs;
    logic        prevDe;
    logic [23:0] prevData;
    logic        prevEn;
    logic        prevRst;

    always @(posedge clk) begin
        prevVs   <= pre_vs;
        prevDe   <= pre_de;
        prevData <= pre_data;
        prevEn   <= EN;
        prevRst  <= rst_n;
    end

    // Frame statistics; cleared by the monitor when clearGen advances.
    int clearGen = 0;
    int seenGen  = 0;
    int lines, pixTotal, curLen, minLen, maxLen, vsPulses;
    int firstData, lastData;
    int vsErr   = 0;
    int passErr = 0;
    int latErr  = 0;
    logic lastPostVs = 1'b0;

    always @(negedge clk) begin
        if (clearGen != seenGen) begin
            seenGen   = clearGen;
            lines     = 0;
            pixTotal  = 0;
            curLen    = 0;
            minLen    = 99999;
            maxLen    = 0;
            vsPulses  = 0;
            firstData = -1;
            lastData  = -1;
        end
        if (rst_n && prevRst) begin
            if (post_vs !== prevVs) vsErr++;
            if (post_vs && !lastPostVs) vsPulses++;
            if (!prevEn && ((post_de !== prevDe) || (post_data !== prevData))) passErr++;
            if (prevEn && post_de && (!prevDe || (post_data !== prevData))) latErr++;
        end
        lastPostVs = post_vs;
        if (post_de) begin
            if (curLen == 0) begin
                lines++;
                if (firstData < 0) firstData = int'(post_data);
            end
            curLen++;
            pixTotal++;
            lastData = int'(post_data);
        end else if (curLen > 0) begin
            if (curLen < minLen) minLen = curLen;
            if (curLen > maxLen) maxLen = curLen;
            curLen = 0;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    task automatic clearStats();
        clearGen++;
    endtask

    task automatic setCfg(input int x, input int y, input int w, input int h);
        x_start = 12'(x);
        y_start = 12'(y);
        crop_w  = 12'(w);
        crop_h  = 12'(h);
    endtask

    task automatic tick(input logic vs, input logic de, input logic [23:0] d);
        @(posedge clk);
        #1;
        pre_vs   = vs;
        pre_de   = de;
        pre_data = d;
    endtask

    // One full frame. chgLine: line at whose start the config is rewritten
    // to the full frame. rstLine: line in which reset is pulsed for 3 cycles
    // after column 8; stats restart once reset is released.
    task automatic applyStimulus(input int chgLine, input int rstLine);
        clearStats();
        repeat (3) tick(1'b1, 1'b0, 24'h0);
        repeat (3) tick(1'b0, 1'b0, 24'h0);
        for (int y = 0; y < VACT; y++) begin
            if (y == chgLine) setCfg(0, 0, HACT, VACT);
            repeat (4) tick(1'b0, 1'b0, 24'h0);
            for (int x = 0; x < HACT; x++) begin
                tick(1'b0, 1'b1, {12'(y), 12'(x)});
                if ((y == rstLine) && (x == 8)) begin
                    rst_n = 1'b0;
                    #1;
                    checkOutput("rst_mid_de",   int'(post_de),   0);
                    checkOutput("rst_mid_data", int'(post_data), 0);
                    checkOutput("rst_mid_vs",   int'(post_vs),   0);
                    repeat (3) @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    clearStats();
                end
            end
            tick(1'b0, 1'b0, 24'h0);
        end
        repeat (4) tick(1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        rst_n    = 1'b0;
        EN       = 1'b1;
        pre_vs   = 1'b0;
        pre_de   = 1'b0;
        pre_data = 24'h0;
        setCfg(5, 3, 16, 12);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_vs",   int'(post_vs),   0);
        checkOutput("reset_de",   int'(post_de),   0);
        checkOutput("reset_data", int'(post_data), 0);
        rst_n = 1'b1;

        // Centre crop 16x12 at (5,3).
        applyStimulus(-1, -1);
        checkOutput("crop_lines", lines,    12);
        checkOutput("crop_min",   minLen,   16);
        checkOutput("crop_max",   maxLen,   16);
        checkOutput("crop_total", pixTotal, 192);
        checkOutput("crop_first", firstData, 24'h003005);
        checkOutput("crop_last",  lastData,  24'h00E014);

        // Pass-through: every input pixel reappears one cycle later.
        EN = 1'b0;
        applyStimulus(-1, -1);
        checkOutput("pass_lines", lines,    24);
        checkOutput("pass_total", pixTotal, 960);
        checkOutput("pass_first", firstData, 24'h000000);
        checkOutput("pass_last",  lastData,  24'h017027);
        EN = 1'b1;

        // Mid-frame change to full frame: current frame stays cropped.
        setCfg(5, 3, 16, 12);
        applyStimulus(6, -1);
        checkOutput("chg_cur_lines", lines,    12);
        checkOutput("chg_cur_total", pixTotal, 192);
        applyStimulus(-1, -1);
        checkOutput("chg_next_lines", lines,    24);
        checkOutput("chg_next_total", pixTotal, 960);
        checkOutput("chg_next_last",  lastData, 24'h017027);

        // Right edge clip: x=30, w=20 on a 40-wide line keeps columns 30..39.
        setCfg(30, 0, 20, 24);
        applyStimulus(-1, -1);
        applyStimulus(-1, -1);
        checkOutput("clip_lines", lines,    24);
        checkOutput("clip_min",   minLen,   10);
        checkOutput("clip_max",   maxLen,   10);
        checkOutput("clip_first", firstData, 24'h00001E);
        checkOutput("clip_last",  lastData,  24'h017027);

        // Zero width: nothing valid, sync still forwarded.
        setCfg(5, 3, 0, 12);
        applyStimulus(-1, -1);
        applyStimulus(-1, -1);
        checkOutput("zero_w_total", pixTotal, 0);
        checkOutput("zero_w_vs",    vsPulses, 1);

        // Reset at line 10: blank for the rest of that frame, next is correct.
        setCfg(5, 3, 16, 12);
        applyStimulus(-1, 10);
        checkOutput("rst_rest_total", pixTotal, 0);
        applyStimulus(-1, -1);
        checkOutput("rst_next_lines", lines,     12);
        checkOutput("rst_next_total", pixTotal,  192);
        checkOutput("rst_next_first", firstData, 24'h003005);

        checkOutput("vs_delay_errs", vsErr,   0);
        checkOutput("latency_errs",  latErr,  0);
        checkOutput("passthru_errs", passErr, 0);

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
